div_operand_prep: RTL and testbench

Upstream operand-preparation stage for the 16-bit reciprocal-approximation divider. Accepts a dividend/divisor pair over a valid/ready handshake and normalizes the divisor by iterative left shift until its MSB is set. It then selects one of four initial reciprocal approximations (IA0–IA3) from the top fraction bits of the normalized divisor. It presents the dividend, normalized divisor, selected IA, shift count and divide-by-zero flag to the divider, holding them until consumed.

---
 rtl/div_pkg.sv | 14 +
 rtl/mux4.sv | 25 ++
 rtl/div_operand_prep.sv | 130 +++++++++++++
 tb/tb_div_operand_prep.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the divider operand-preparation stage.
package div_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned IA_SEL_LSB = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mux4.sv
// Generic 4:1 mux; picks one of four reciprocal approximations.
module mux4 #(
  parameter int unsigned W = 16
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y_c
);

  // Pure combinational select.
  always_comb begin
    y_c = d0;
    case (sel)
      2'd0: y_c = d0;
      2'd1: y_c = d1;
      2'd2: y_c = d2;
      2'd3: y_c = d3;
      default: y_c = d0;
    endcase
  end

endmodule

// File: rtl/div_operand_prep.sv
// Divisor normalisation and initial-approximation selection ahead of the
// reciprocal divider. Divisor is left-shifted until its MSB is set; the
// shift count and an approximation chosen from the normalised divisor are
// held with the untouched dividend until the divider takes them.
module div_operand_prep
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] ia0,
  input  logic [WIDTH-1:0] ia1,
  input  logic [WIDTH-1:0] ia2,
  input  logic [WIDTH-1:0] ia3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_norm,
  output logic [WIDTH-1:0] ia_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             div_zero
);

  state_t           state;
  state_t           state_n;
  logic             accept_c;
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b_n;
  logic [CNT_W-1:0] cnt_n;
  logic             dz_n;
  logic             ov_n;
  logic             rdy_n;
  logic             ia_load;
  logic [WIDTH-1:0] ia_sel_c;

  assign accept_c = in_valid && in_ready;

  // Approximation is chosen from the divisor value that will sit in b_norm.
  mux4 #(.W(WIDTH)) u_ia_mux (
    .sel (b_n[IA_SEL_LSB +: 2]),
    .d0  (ia0),
    .d1  (ia1),
    .d2  (ia2),
    .d3  (ia3),
    .y_c (ia_sel_c)
  );

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_n = state;
    a_n     = a_out;
    b_n     = b_norm;
    cnt_n   = shift_cnt;
    dz_n    = div_zero;
    ov_n    = out_valid;
    rdy_n   = 1'b0;
    ia_load = 1'b0;
    case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (accept_c) begin
          a_n   = a_in;
          b_n   = b_in;
          cnt_n = '0;
          dz_n  = (b_in == '0);
          rdy_n = 1'b0;
          if ((b_in == '0) || b_in[WIDTH-1]) begin
            state_n = HOLD;
            ov_n    = 1'b1;
            ia_load = 1'b1;
          end else begin
            state_n = NORM;
          end
        end
      end
      NORM: begin
        b_n   = b_norm << 1;
        cnt_n = shift_cnt + CNT_W'(1);
        // Bit below the MSB set: this shift is the last one.
        if (b_norm[WIDTH-2]) begin
          state_n = HOLD;
          ov_n    = 1'b1;
          ia_load = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = IDLE;
          ov_n    = 1'b0;
          dz_n    = 1'b0;
          rdy_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        ov_n    = 1'b0;
        dz_n    = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
      a_out     <= '0;
      b_norm    <= '0;
      ia_out    <= '0;
      shift_cnt <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= rdy_n;
      out_valid <= ov_n;
      div_zero  <= dz_n;
      a_out     <= a_n;
      b_norm    <= b_n;
      shift_cnt <= cnt_n;
      if (ia_load) begin
        ia_out <= ia_sel_c;
      end
    end
  end

endmodule

// File: tb/tb_div_operand_prep.sv
// Self-checking bench for div_operand_prep: directed cases, backpressure,
// mid-operation reset and randomized operands against a behavioural model.
module tb_div_operand_prep;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in, b_in;
  logic [15:0] ia0, ia1, ia2, ia3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a_out, b_norm, ia_out;
  logic [3:0]  shift_cnt;
  logic        div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  div_operand_prep dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .ia0       (ia0),
    .ia1       (ia1),
    .ia2       (ia2),
    .ia3       (ia3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_norm    (b_norm),
    .ia_out    (ia_out),
    .shift_cnt (shift_cnt),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference: find how far the divisor must move for its top bit to be set.
  function automatic int model_shift(input logic [15:0] b);
    if (b == 16'h0) return 0;
    for (int i = 15; i >= 0; i--) begin
      if (b[i]) return 15 - i;
    end
    return 0;
  endfunction

  function automatic logic [15:0] model_ia(input logic [15:0] bn);
    int idx;
    idx = int'(bn / 16'h2000) % 4;  // the two fraction bits below the MSB
    case (idx)
      0: return ia0;
      1: return ia1;
      2: return ia2;
      default: return ia3;
    endcase
  endfunction

  // One complete operation: accept, latency, payload, optional stall, handshake.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input int hold);
    int          s;
    int          lat;
    int          guard;
    logic [15:0] exp_bn;
    logic [15:0] exp_ia;
    logic        exp_dz;
    s      = model_shift(b);
    exp_bn = b * (16'h1 << s);
    exp_dz = (b == 16'h0);
    exp_ia = exp_dz ? ia0 : model_ia(exp_bn);

    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_wait: in_ready=%b required 1", name, in_ready);
      return;
    end
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = 16'($urandom);
    b_in     = 16'($urandom);

    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != s + 1) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, lat, s + 1);
    end

    for (int h = 0; h <= hold; h++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || a_out !== a || b_norm !== exp_bn || ia_out !== exp_ia ||
          shift_cnt !== 4'(s) || div_zero !== exp_dz || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s payload(cyc %0d): ov=%b a=%h bn=%h ia=%h sc=%0d dz=%b rdy=%b required ov=1 a=%h bn=%h ia=%h sc=%0d dz=%b rdy=0",
                 name, h, out_valid, a_out, b_norm, ia_out, shift_cnt, div_zero, in_ready,
                 a, exp_bn, exp_ia, s, exp_dz);
      end
      if (h < hold) begin
        // Stalled: new offers must be ignored.
        in_valid = 1'b1;
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);
        @(negedge clk);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL %s release: ov=%b rdy=%b dz=%b required ov=0 rdy=1 dz=0",
               name, out_valid, in_ready, div_zero);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = 16'h0;
    b_in      = 16'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || div_zero !== 1'b0 || a_out !== 16'h0 || b_norm !== 16'h0 ||
        ia_out !== 16'h0 || shift_cnt !== 4'h0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: ov=%b dz=%b a=%h bn=%h ia=%h sc=%0d rdy=%b required all 0",
               out_valid, div_zero, a_out, b_norm, ia_out, shift_cnt, in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    run_op("msb_set",   16'h1234, 16'h8000, 0);
    n_cmp++;
    if (ia_out !== 16'h0000 && 16'hE666 !== ia0) begin
      n_bad++;
      $display("FAIL ia0_const: ia0=%h required E666", ia0);
    end
    run_op("b_00f0",    16'hBEEF, 16'h00F0, 0);
    run_op("b_5000",    16'h0F0F, 16'h5000, 0);
    run_op("b_0001",    16'hFFFF, 16'h0001, 0);
    run_op("div_zero",  16'h7777, 16'h0000, 0);
    run_op("sel_ia2",   16'h0001, 16'h0C00, 0);
  endtask

  task automatic test_backpressure();
    run_op("bp_norm", 16'hCAFE, 16'h0123, 5);
    run_op("bp_zero", 16'h0042, 16'h0000, 5);
  endtask

  task automatic test_mid_reset();
    int saw_valid;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    a_in     = 16'h5A5A;
    b_in     = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || div_zero !== 1'b0 || a_out !== 16'h0 || b_norm !== 16'h0 ||
        ia_out !== 16'h0 || shift_cnt !== 4'h0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_values: ov=%b dz=%b a=%h bn=%h ia=%h sc=%0d rdy=%b required all 0",
               out_valid, div_zero, a_out, b_norm, ia_out, shift_cnt, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_ready: in_ready=%b required 1", in_ready);
    end
    saw_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) saw_valid++;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_valid != 0) begin
      n_bad++;
      $display("FAIL midreset_dropped: out_valid seen %0d cycles required 0", saw_valid);
    end
    run_op("after_reset", 16'h4321, 16'h0001, 1);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 16);
      run_op($sformatf("rand%0d", i), a, b, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    ia0 = 16'hE666;
    ia1 = 16'hBAE1;
    ia2 = 16'h9D89;
    ia3 = 16'h8A3D;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
